// File: rtl/i2c_temp_poll_sched.sv
// i2c_temp_poll_sched
// Sequences a shared 2-byte I2C read engine across up to 8 temperature
// sensors.
//
// Behaviour:
// - Every POLL_CYCLES clocks, the sensors are swept in address order.
// - A failed read (NACK or timeout) is retried up to MAX_RETRY extra times.
// - Each sensor's last good 16-bit reading is kept and is readable via rd_sel.
//
// Optional feature: define TEMP_ALERT_EN to enable per-sensor over-temperature
// flags. Each flag compares data[15:7] against thresh. When the macro is
// undefined, alert_mask is tied to 0 and thresh is ignored.
module i2c_temp_poll_sched #(
  parameter int         NUM_SENSORS    = 4,
  parameter logic [6:0] BASE_ADDR      = 7'h48,
  parameter int         POLL_CYCLES    = 32000000,
  parameter int         MAX_RETRY      = 2,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_start,
  output logic [6:0]  m_addr,
  input  logic        m_busy,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic [15:0] m_rdata,
  input  logic [2:0]  rd_sel,
  output logic [15:0] rd_temp,
  output logic [7:0]  valid_mask,
  output logic [7:0]  err_mask,
  output logic        sweep_done,
  output logic [7:0]  alert_mask,
  input  logic [8:0]  thresh
);

  localparam int TW = $clog2(POLL_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          en_prev_q;
  logic          armed_q;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    retry_q, retry_d;
  logic [OW-1:0] tmo_q, tmo_d;
  logic [6:0]    addr_q, addr_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          timer_wrap;
  logic          first_start;
  logic          sweep_req;
  logic          do_store;
  logic          do_fail;
  logic          alert_hit;

  logic [15:0]   temp_all [8];
  logic [7:0]    valid_all;
  logic [7:0]    err_all;
  logic [7:0]    alert_all;

  // The period timer is free-running while enabled and is parked at 0
  // while disabled.
  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TW'(POLL_CYCLES - 1)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  assign timer_wrap  = enable && (timer_q == TW'(POLL_CYCLES - 1));
  // Only the very first enable rising edge after reset kicks off a sweep
  // early. All later sweeps are paced by the timer.
  assign first_start = enable && !en_prev_q && !armed_q;
  assign sweep_req   = timer_wrap || first_start;

  // Sweep FSM next-state logic. A request that arrives outside IDLE is
  // dropped, so an overrunning sweep simply skips that period.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    m_start    = 1'b0;
    sweep_done = 1'b0;
    do_store   = 1'b0;
    do_fail    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sweep_req) begin
          idx_d   = 3'd0;
          retry_d = 3'd0;
          addr_d  = BASE_ADDR;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!m_busy) begin
          m_start = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done pulse outranks a timeout that expires on the same cycle.
        if (m_done && !m_nack) begin
          rdata_d = m_rdata;
          state_d = S_STORE;
        // The timeout fires on the TIMEOUT_CYCLES-th cycle spent waiting.
        end else if (m_done || (tmo_q == OW'(TIMEOUT_CYCLES - 1))) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 3'd1;
            state_d = S_ISSUE;
          end else begin
            do_fail = 1'b1;
            state_d = S_NEXT;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_STORE: begin
        do_store = 1'b1;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        // Dropping enable abandons the rest of the sweep without sweep_done.
        if (!enable) begin
          state_d = S_IDLE;
        end else if (idx_q == 3'(NUM_SENSORS - 1)) begin
          sweep_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          retry_d = 3'd0;
          addr_d  = BASE_ADDR + {4'd0, idx_q} + 7'd1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registers for the control path and the period timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      en_prev_q <= 1'b0;
      armed_q   <= 1'b0;
      idx_q     <= 3'd0;
      retry_q   <= 3'd0;
      tmo_q     <= '0;
      addr_q    <= 7'd0;
      rdata_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      en_prev_q <= enable;
      armed_q   <= armed_q | first_start;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m_addr = addr_q;

`ifdef TEMP_ALERT_EN
  assign alert_hit = $signed(rdata_q[15:7]) >= $signed(thresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign alert_hit     = 1'b0;
`endif

  // Per-sensor storage. Slots beyond NUM_SENSORS are constant zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sensor
    if (gi < NUM_SENSORS) begin : g_live
      logic [15:0] temp_q;
      logic        valid_q;
      logic        err_q;
      logic        alert_q;

      // A good read updates the value and the valid/error bits. A final
      // failure only flags an error and keeps the old value.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          temp_q  <= 16'd0;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          alert_q <= 1'b0;
        end else if (do_store && (idx_q == 3'(gi))) begin
          temp_q  <= rdata_q;
          valid_q <= 1'b1;
          err_q   <= 1'b0;
          alert_q <= alert_hit;
        end else if (do_fail && (idx_q == 3'(gi))) begin
          err_q   <= 1'b1;
          alert_q <= 1'b0;
        end
      end

      assign temp_all[gi]  = temp_q;
      assign valid_all[gi] = valid_q;
      assign err_all[gi]   = err_q;
      assign alert_all[gi] = alert_q;
    end else begin : g_tied
      assign temp_all[gi]  = 16'd0;
      assign valid_all[gi] = 1'b0;
      assign err_all[gi]   = 1'b0;
      assign alert_all[gi] = 1'b0;
    end
  end

  assign valid_mask = valid_all;
  assign err_mask   = err_all;
`ifdef TEMP_ALERT_EN
  assign alert_mask = alert_all;
`else
  logic unused_alert;
  assign unused_alert = ^alert_all;
  assign alert_mask   = 8'd0;
`endif

  // Combinational readout mux. Unpopulated indices read as zero.
  always_comb begin
    rd_temp = 16'd0;
    if (int'(rd_sel) < NUM_SENSORS) begin
      rd_temp = temp_all[rd_sel];
    end
  end

endmodule

// File: tb/tb_i2c_temp_poll_sched.sv
// Testbench for i2c_temp_poll_sched. It drives a 20-cycle byte-engine model
// and checks each sweep against a per-sensor outcome model.
module tb_i2c_temp_poll_sched;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              m_start;
  logic [6:0]        m_addr;
  logic              m_busy;
  logic              m_done = 1'b0;
  logic              m_nack = 1'b0;
  logic [15:0]       m_rdata = 16'd0;
  logic [2:0]        rd_sel = 3'd0;
  logic [15:0]       rd_temp;
  logic [7:0]        valid_mask;
  logic [7:0]        err_mask;
  logic              sweep_done;
  logic [7:0]        alert_mask;
  logic signed [8:0] thresh = 9'sd0;

  logic eng_busy = 1'b0;
  logic force_busy = 1'b0;
  assign m_busy = eng_busy | force_busy;

  i2c_temp_poll_sched #(
    .NUM_SENSORS(4), .BASE_ADDR(7'h48), .POLL_CYCLES(2000),
    .MAX_RETRY(2), .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_start(m_start), .m_addr(m_addr), .m_busy(m_busy),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .rd_sel(rd_sel), .rd_temp(rd_temp),
    .valid_mask(valid_mask), .err_mask(err_mask),
    .sweep_done(sweep_done), .alert_mask(alert_mask), .thresh(thresh)
  );

  always #5 clk = ~clk;

  // Per-sensor engine behaviour for the current sweep.
  logic [15:0] cfg_data [4];
  int          cfg_nack [4];
  bit          cfg_silent [4];

  // Log of every m_start seen, with the address and the cycle number.
  logic [6:0]  log_addr [$];
  int          log_cyc [$];
  int          log_base = 0;

  int cyc = 0;
  int sd_cnt = 0;
  int eng_cnt = 0;
  logic eng_nack_n = 1'b0;
  logic [15:0] eng_data_n = 16'd0;

  // Reference state.
  logic [15:0] exp_temp [8];
  logic [7:0]  exp_valid = 8'd0;
  logic [7:0]  exp_err = 8'd0;
  logic [7:0]  exp_alert = 8'd0;

  int n_assert = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sweep_done === 1'b1) sd_cnt <= sd_cnt + 1;

  function automatic int prior_attempts(input logic [6:0] a);
    int n = 0;
    for (int j = log_base; j < log_addr.size(); j++)
      if (log_addr[j] == a) n++;
    return n;
  endfunction

  // Engine model. It raises m_done 20 clocks after an accepted m_start. A
  // silent sensor never answers. A sensor NACKs its first cfg_nack attempts.
  always @(posedge clk) begin
    if (!reset_n) begin
      eng_cnt  <= 0;
      eng_busy <= 1'b0;
      m_done   <= 1'b0;
      m_nack   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          m_done   <= 1'b1;
          m_nack   <= eng_nack_n;
          m_rdata  <= eng_data_n;
          eng_busy <= 1'b0;
        end
      end
      if (m_start === 1'b1) begin
        if (!cfg_silent[m_addr[1:0]]) begin
          eng_cnt    <= 20;
          eng_busy   <= 1'b1;
          eng_nack_n <= (prior_attempts(m_addr) < cfg_nack[m_addr[1:0]]);
          eng_data_n <= cfg_data[m_addr[1:0]];
        end
        $display("[%0d] m_start addr=0x%02h", cyc, m_addr);
        log_addr.push_back(m_addr);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_all_ack();
    for (int i = 0; i < 4; i++) begin
      cfg_data[i]   = 16'h1900 + 16'(i);
      cfg_nack[i]   = 0;
      cfg_silent[i] = 1'b0;
    end
    log_base = log_addr.size();
  endtask

  // Predict one sweep from the sensor outcomes, wait for sweep_done, then
  // compare the transaction log, the masks and every readout slot.
  task automatic run_sweep(input string tag);
    logic [6:0] exp_log [$];
    int start_sd;
    int k;
    int got;
    exp_log = {};
    for (int i = 0; i < 4; i++) begin
      int att;
      bit ok;
      if (cfg_silent[i] || cfg_nack[i] > 2) begin
        att = 3; ok = 1'b0;
      end else begin
        att = cfg_nack[i] + 1; ok = 1'b1;
      end
      for (int a = 0; a < att; a++) exp_log.push_back(7'h48 + 7'(i));
      if (ok) begin
        exp_temp[i]  = cfg_data[i];
        exp_valid[i] = 1'b1;
        exp_err[i]   = 1'b0;
`ifdef TEMP_ALERT_EN
        exp_alert[i] = ($signed(cfg_data[i][15:7]) >= thresh);
`endif
      end else begin
        exp_err[i]   = 1'b1;
        exp_alert[i] = 1'b0;
      end
    end
    start_sd = sd_cnt;
    k = 0;
    while (sd_cnt == start_sd && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".sweep_done"}, 32'(sd_cnt - start_sd), 32'd1);
    got = log_addr.size() - log_base;
    chk({tag, ".n_start"}, 32'(got), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < got; i++)
      chk($sformatf("%s.addr%0d", tag, i), 32'(log_addr[log_base + i]), 32'(exp_log[i]));
    chk({tag, ".valid"}, 32'(valid_mask), 32'(exp_valid));
    chk({tag, ".err"}, 32'(err_mask), 32'(exp_err));
    chk({tag, ".alert"}, 32'(alert_mask), 32'(exp_alert));
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      @(negedge clk);
      chk($sformatf("%s.rd_temp%0d", tag, s), 32'(rd_temp), (s < 4) ? 32'(exp_temp[s]) : 32'd0);
    end
    $display("sweep %s: %0d starts valid=0x%02h err=0x%02h alert=0x%02h",
             tag, got, valid_mask, err_mask, alert_mask);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".m_start"}, 32'(m_start), 32'd0);
    chk({tag, ".m_addr"}, 32'(m_addr), 32'd0);
    chk({tag, ".valid"}, 32'(valid_mask), 32'd0);
    chk({tag, ".err"}, 32'(err_mask), 32'd0);
    chk({tag, ".sweep_done"}, 32'(sweep_done), 32'd0);
    chk({tag, ".alert"}, 32'(alert_mask), 32'd0);
    chk({tag, ".rd_temp"}, 32'(rd_temp), 32'd0);
  endtask

  initial begin
    int s0;
    int d;
    int k;
    for (int i = 0; i < 8; i++) exp_temp[i] = 16'd0;
    cfg_all_ack();

    // Reset state, both during reset and after release with enable low.
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("idle_disabled");

    // The first sweep starts on the enable edge. Every sensor ACKs.
    enable = 1'b1;
    run_sweep("all_ack");

    // Sensor 1 NACKs twice, then ACKs on the final retry.
    cfg_all_ack();
    cfg_nack[1] = 2;
    run_sweep("nack_retry");

    // Sensor 3 is silent. Expect three timeouts and an error bit, with the
    // old value kept.
    cfg_all_ack();
    cfg_silent[3] = 1'b1;
    cfg_data[3]   = 16'hDEAD;
    run_sweep("timeout");
    s0 = log_cyc[log_base];
    if (log_addr.size() >= log_base + 6) begin
      for (int i = 4; i < 6; i++) begin
        d = log_cyc[log_base + i] - log_cyc[log_base + i - 1];
        chk($sformatf("timeout.gap%0d", i), 32'((d >= 200) && (d <= 205)), 32'd1);
      end
    end

    // Hold m_busy across the next sweep start. No start is allowed until it
    // drops, and then exactly one start follows.
    cfg_all_ack();
    force_busy = 1'b1;
    while (cyc < s0 + 2050) @(negedge clk);
    chk("busy.no_start", 32'(log_addr.size() - log_base), 32'd0);
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy.one_start", 32'(log_addr.size() - log_base), 32'd1);
    if (log_addr.size() > log_base)
      chk("busy.first_addr", 32'(log_addr[log_base]), 32'h48);
    run_sweep("busy");

    // Randomised sweeps: random data and NACK counts, at most one silent sensor.
    for (int r = 0; r < 4; r++) begin
      cfg_all_ack();
      thresh = 9'($urandom_range(0, 511));
      for (int i = 0; i < 4; i++) begin
        cfg_data[i] = 16'($urandom);
        cfg_nack[i] = $urandom_range(0, 3);
      end
      k = $urandom_range(0, 7);
      if (k < 4) cfg_silent[k] = 1'b1;
      run_sweep($sformatf("rand%0d", r));
    end

    // Alert threshold: 31 C against a 30 C threshold, then 25 C.
    cfg_all_ack();
    thresh = 9'sd60;
    cfg_data[0] = 16'h1F00;
    run_sweep("alert_hi");
`ifdef TEMP_ALERT_EN
    chk("alert_hi.bit0", 32'(alert_mask[0]), 32'd1);
`else
    chk("alert_hi.bit0", 32'(alert_mask[0]), 32'd0);
`endif
    cfg_all_ack();
    run_sweep("alert_lo");
    chk("alert_lo.bit0", 32'(alert_mask[0]), 32'd0);

    // Reset while a transaction is in flight, then resume with enable high.
    rd_sel = 3'd0;
    cfg_all_ack();
    k = 0;
    while (log_addr.size() == log_base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reset.started", 32'(log_addr.size() > log_base), 32'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    for (int i = 0; i < 8; i++) exp_temp[i] = 16'd0;
    exp_valid = 8'd0;
    exp_err   = 8'd0;
    exp_alert = 8'd0;
    repeat (2) @(negedge clk);
    log_base = log_addr.size();
    reset_n = 1'b1;
    run_sweep("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
